// File: rtl/alu_rs_if.sv
// Dispatch, common-data-bus and issue bundle for the ALU reservation station.
// The master side is the dispatcher/CDB producers, the slave side is the station.
interface alu_rs_if #(
    parameter int ROB_W = 4
);
    // Dispatch channel
    logic             in_valid;
    logic [ROB_W-1:0] in_rob_id;
    logic [5:0]       in_opcode;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;
    logic             in_qj_valid;
    logic             in_qk_valid;
    logic [ROB_W-1:0] in_qj;
    logic [ROB_W-1:0] in_qk;
    logic [31:0]      in_imm;
    logic [31:0]      in_pc;
    logic             full;

    // Broadcast buses snooped for operand wakeup
    logic             alu_cdb_valid;
    logic [ROB_W-1:0] alu_cdb_rob_id;
    logic [31:0]      alu_cdb_value;
    logic             lsb_cdb_valid;
    logic [ROB_W-1:0] lsb_cdb_rob_id;
    logic [31:0]      lsb_cdb_value;

    // Issue channel into the ALU work_en operand port
    logic             alu_en;
    logic [ROB_W-1:0] alu_rob_id;
    logic [5:0]       alu_opcode;
    logic [31:0]      alu_rs1;
    logic [31:0]      alu_rs2;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;

    modport master (
        output in_valid, in_rob_id, in_opcode, in_vj, in_vk,
        output in_qj_valid, in_qk_valid, in_qj, in_qk, in_imm, in_pc,
        output alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
        output lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
        input  full,
        input  alu_en, alu_rob_id, alu_opcode, alu_rs1, alu_rs2, alu_imm, alu_pc
    );

    modport slave (
        input  in_valid, in_rob_id, in_opcode, in_vj, in_vk,
        input  in_qj_valid, in_qk_valid, in_qj, in_qk, in_imm, in_pc,
        input  alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
        input  lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
        output full,
        output alu_en, alu_rob_id, alu_opcode, alu_rs1, alu_rs2, alu_imm, alu_pc
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU/branch instructions until both
// operands are known (at dispatch or by snooping the ALU and LSB CDBs), then
// issues at most one ready instruction per cycle into the single-cycle ALU.
// Optional build macro ALU_RS_OLDEST_FIRST_EN: each slot keeps a saturating
// 8-bit age and select prefers the oldest ready slot instead of the lowest index.
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int ROB_W   = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    clear,
    alu_rs_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Per-slot state
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] qjValid_q, qjValid_d;
    logic [ENTRIES-1:0] qkValid_q, qkValid_d;
    logic [ROB_W-1:0]   robId_q  [ENTRIES];
    logic [ROB_W-1:0]   robId_d  [ENTRIES];
    logic [ROB_W-1:0]   qj_q     [ENTRIES];
    logic [ROB_W-1:0]   qj_d     [ENTRIES];
    logic [ROB_W-1:0]   qk_q     [ENTRIES];
    logic [ROB_W-1:0]   qk_d     [ENTRIES];
    logic [5:0]         opcode_q [ENTRIES];
    logic [5:0]         opcode_d [ENTRIES];
    logic [31:0]        vj_q     [ENTRIES];
    logic [31:0]        vj_d     [ENTRIES];
    logic [31:0]        vk_q     [ENTRIES];
    logic [31:0]        vk_d     [ENTRIES];
    logic [31:0]        imm_q    [ENTRIES];
    logic [31:0]        imm_d    [ENTRIES];
    logic [31:0]        pc_q     [ENTRIES];
    logic [31:0]        pc_d     [ENTRIES];
`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [7:0]         age_q    [ENTRIES];
    logic [7:0]         age_d    [ENTRIES];
    logic [7:0]         bestAge;
`endif

    // Issue registers feeding the ALU
    logic             aluEn_q, aluEn_d;
    logic [ROB_W-1:0] aluRobId_q, aluRobId_d;
    logic [5:0]       aluOpcode_q, aluOpcode_d;
    logic [31:0]      aluRs1_q, aluRs1_d;
    logic [31:0]      aluRs2_q, aluRs2_d;
    logic [31:0]      aluImm_q, aluImm_d;
    logic [31:0]      aluPc_q, aluPc_d;

    // Slot bookkeeping
    logic [ENTRIES-1:0] ready;
    logic               full;
    logic               issueValid;
    logic [IDX_W-1:0]   issueIdx;
    logic               allocValid;
    logic [IDX_W-1:0]   allocIdx;

    // Resolves one operand against both CDBs; returns {still pending, value}.
    // The ALU bus is checked first so it wins a (protocol-illegal) double match.
    function automatic logic [32:0] snoop(
        input logic             pending,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      value,
        input logic             aValid,
        input logic [ROB_W-1:0] aTag,
        input logic [31:0]      aValue,
        input logic             lValid,
        input logic [ROB_W-1:0] lTag,
        input logic [31:0]      lValue
    );
        logic [32:0] result;
        result = {pending, value};
        if (pending && aValid && (tag == aTag)) begin
            result = {1'b0, aValue};
        end else if (pending && lValid && (tag == lTag)) begin
            result = {1'b0, lValue};
        end
        return result;
    endfunction

    assign ready = busy_q & ~qjValid_q & ~qkValid_q;
    assign full  = &busy_q;

    // Pick the slot to issue: oldest ready slot (lowest index on ties) when
    // ages are kept, otherwise simply the lowest-index ready slot.
    always_comb begin
        issueValid = 1'b0;
        issueIdx   = '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
        bestAge    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready[i] && (!issueValid || (age_q[i] > bestAge))) begin
                issueValid = 1'b1;
                issueIdx   = IDX_W'(i);
                bestAge    = age_q[i];
            end
        end
`else
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issueValid = 1'b1;
                issueIdx   = IDX_W'(i);
            end
        end
`endif
    end

    // Pick the lowest free slot for a dispatch; a dispatch while full is dropped.
    always_comb begin
        allocIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                allocIdx = IDX_W'(i);
            end
        end
        allocValid = bus.in_valid && !full;
    end

    // Next state: clear beats everything (even a stalled rdy), otherwise when
    // rdy is high apply wakeup, issue and allocate; with rdy low all state holds.
    always_comb begin
        busy_d      = busy_q;
        qjValid_d   = qjValid_q;
        qkValid_d   = qkValid_q;
        robId_d     = robId_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        opcode_d    = opcode_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
`ifdef ALU_RS_OLDEST_FIRST_EN
        age_d       = age_q;
`endif
        aluEn_d     = aluEn_q;
        aluRobId_d  = aluRobId_q;
        aluOpcode_d = aluOpcode_q;
        aluRs1_d    = aluRs1_q;
        aluRs2_d    = aluRs2_q;
        aluImm_d    = aluImm_q;
        aluPc_d     = aluPc_q;

        if (clear) begin
            busy_d  = '0;
            aluEn_d = 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i]) begin
                    {qjValid_d[i], vj_d[i]} = snoop(qjValid_q[i], qj_q[i], vj_q[i],
                        bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                        bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
                    {qkValid_d[i], vk_d[i]} = snoop(qkValid_q[i], qk_q[i], vk_q[i],
                        bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                        bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
`ifdef ALU_RS_OLDEST_FIRST_EN
                    if (age_q[i] != 8'hFF) begin
                        age_d[i] = age_q[i] + 8'd1;
                    end
`endif
                end
            end

            aluEn_d = issueValid;
            if (issueValid) begin
                busy_d[issueIdx] = 1'b0;
                aluRobId_d       = robId_q[issueIdx];
                aluOpcode_d      = opcode_q[issueIdx];
                aluRs1_d         = vj_q[issueIdx];
                aluRs2_d         = vk_q[issueIdx];
                aluImm_d         = imm_q[issueIdx];
                aluPc_d          = pc_q[issueIdx];
            end

            if (allocValid) begin
                busy_d[allocIdx]   = 1'b1;
                robId_d[allocIdx]  = bus.in_rob_id;
                opcode_d[allocIdx] = bus.in_opcode;
                qj_d[allocIdx]     = bus.in_qj;
                qk_d[allocIdx]     = bus.in_qk;
                imm_d[allocIdx]    = bus.in_imm;
                pc_d[allocIdx]     = bus.in_pc;
                {qjValid_d[allocIdx], vj_d[allocIdx]} = snoop(bus.in_qj_valid, bus.in_qj, bus.in_vj,
                    bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                    bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
                {qkValid_d[allocIdx], vk_d[allocIdx]} = snoop(bus.in_qk_valid, bus.in_qk, bus.in_vk,
                    bus.alu_cdb_valid, bus.alu_cdb_rob_id, bus.alu_cdb_value,
                    bus.lsb_cdb_valid, bus.lsb_cdb_rob_id, bus.lsb_cdb_value);
`ifdef ALU_RS_OLDEST_FIRST_EN
                age_d[allocIdx] = 8'd0;
`endif
            end
        end
    end

    // Control and issue registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            aluEn_q     <= 1'b0;
            aluRobId_q  <= '0;
            aluOpcode_q <= '0;
            aluRs1_q    <= '0;
            aluRs2_q    <= '0;
            aluImm_q    <= '0;
            aluPc_q     <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= 8'd0;
            end
`endif
        end else begin
            busy_q      <= busy_d;
            aluEn_q     <= aluEn_d;
            aluRobId_q  <= aluRobId_d;
            aluOpcode_q <= aluOpcode_d;
            aluRs1_q    <= aluRs1_d;
            aluRs2_q    <= aluRs2_d;
            aluImm_q    <= aluImm_d;
            aluPc_q     <= aluPc_d;
`ifdef ALU_RS_OLDEST_FIRST_EN
            age_q       <= age_d;
`endif
        end
    end

    // Slot payload registers; contents only matter while the busy bit is set.
    always_ff @(posedge clk) begin
        qjValid_q <= qjValid_d;
        qkValid_q <= qkValid_d;
        robId_q   <= robId_d;
        qj_q      <= qj_d;
        qk_q      <= qk_d;
        opcode_q  <= opcode_d;
        vj_q      <= vj_d;
        vk_q      <= vk_d;
        imm_q     <= imm_d;
        pc_q      <= pc_d;
    end

    assign bus.full       = full;
    assign bus.alu_en     = aluEn_q;
    assign bus.alu_rob_id = aluRobId_q;
    assign bus.alu_opcode = aluOpcode_q;
    assign bus.alu_rs1    = aluRs1_q;
    assign bus.alu_rs2    = aluRs2_q;
    assign bus.alu_imm    = aluImm_q;
    assign bus.alu_pc     = aluPc_q;

endmodule
